// File: rtl/sp_bram16k.sv
// sp_bram16k: behavioural 16 Kbit single-port synchronous block RAM with a
// global asynchronous reset on the output registers.
//
// The storage is 16384 bits, organised as 16384/BIT_WIDTH words. The address
// is a bit address, and the low log2(BIT_WIDTH) bits of ad are ignored.
//
// Parameters
//   READ_MODE   0 = bypass (1-cycle read), 1 = extra output register gated by oce
//   WRITE_MODE  00 normal, 01 write-through, 10 read-before-write, 11 = 00
//   BIT_WIDTH   word width, one of 1/2/4/8/16/32
//   BLK_SEL     block identity; the port is active only when blksel matches
//   INIT_RAM_00 initial contents of memory bits 0..255; the rest start at 0
//
// Ports
//   clock    in   1   rising-edge clock
//   reset_n  in   1   async active-low; clears the output registers only
//   ce       in   1   chip enable
//   oce      in   1   output-register enable (pipeline mode only)
//   wre      in   1   1 = write, 0 = read
//   blksel   in   3   block select
//   ad       in  14   bit address
//   di       in  32   write data, di[W-1:0] used
//   dout     out 32   read data in dout[W-1:0], upper bits zero
module sp_bram16k #(
    parameter logic         READ_MODE   = 1'b0,
    parameter logic [1:0]   WRITE_MODE  = 2'b00,
    parameter int           BIT_WIDTH   = 8,
    parameter logic [2:0]   BLK_SEL     = 3'b000,
    parameter logic [255:0] INIT_RAM_00 = 256'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        oce,
    input  logic        wre,
    input  logic [2:0]  blksel,
    input  logic [13:0] ad,
    input  logic [31:0] di,
    output logic [31:0] dout
);

    localparam int W        = BIT_WIDTH;
    localparam int MEM_BITS = 16384;

    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32)) begin : g_bad_width
        $error("sp_bram16k: BIT_WIDTH must be 1, 2, 4, 8, 16 or 32");
    end

    // The memory is a flat bit vector. A word starts at the bit address with
    // its low log2(W) bits cleared. Only the first 256 bits have
    // non-zero initial contents.
    logic [MEM_BITS-1:0] mem = MEM_BITS'(INIT_RAM_00);

    logic [13:0]  base_addr;
    logic [W-1:0] rd_word;
    logic         active;
    logic [W-1:0] ram_q_p0;
    logic [W-1:0] q_out;

    assign base_addr = ad & ~14'(W - 1);
    assign rd_word   = mem[base_addr +: W];
    assign active    = ce && (blksel == BLK_SEL);

    // Port-select bits and the top of di are not needed for narrow words.
    logic unused_inputs;
    assign unused_inputs = ^{di, ad, oce};

    // Array write. While reset_n is low, no write happens, even on a clock edge.
    always_ff @(posedge clock) begin
        if (reset_n && active && wre) begin
            mem[base_addr +: W] <= di[W-1:0];
        end
    end

    // Stage p0: the output latch. rd_word is sampled before the write lands,
    // so read-before-write returns the old contents of the word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_q_p0 <= '0;
        end else if (active) begin
            if (!wre) begin
                ram_q_p0 <= rd_word;
            end else begin
                case (WRITE_MODE)
                    2'b01:   ram_q_p0 <= di[W-1:0];
                    2'b10:   ram_q_p0 <= rd_word;
                    default: ram_q_p0 <= ram_q_p0;
                endcase
            end
        end
    end

    if (READ_MODE) begin : g_pipe
        logic [W-1:0] ram_q_p1;

        // Stage p1: the optional output register, which advances only when oce is high.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                ram_q_p1 <= '0;
            end else if (oce) begin
                ram_q_p1 <= ram_q_p0;
            end
        end

        assign q_out = ram_q_p1;
    end else begin : g_bypass
        assign q_out = ram_q_p0;
    end

    assign dout = 32'(q_out);

endmodule

// File: tb/tb_sp_bram16k.sv
// Directed bench for sp_bram16k. Several configurations share one stimulus
// bus. Each one answers to its own blksel, so a test can address one group
// of instances at a time.
module tb_sp_bram16k;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        oce;
    logic        wre;
    logic [2:0]  blksel;
    logic [13:0] ad;
    logic [31:0] di;
    logic [31:0] dout_n, dout_wt, dout_rbw, dout_pp, dout_in, dout_32, dout_1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    // blksel 0: four W=8 instances (normal, write-through, read-before-write, pipeline)
    sp_bram16k #(.READ_MODE(1'b0), .WRITE_MODE(2'b00), .BIT_WIDTH(8), .BLK_SEL(3'd0)) u_norm (
        .clock(clock), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre),
        .blksel(blksel), .ad(ad), .di(di), .dout(dout_n));
    sp_bram16k #(.READ_MODE(1'b0), .WRITE_MODE(2'b01), .BIT_WIDTH(8), .BLK_SEL(3'd0)) u_wt (
        .clock(clock), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre),
        .blksel(blksel), .ad(ad), .di(di), .dout(dout_wt));
    sp_bram16k #(.READ_MODE(1'b0), .WRITE_MODE(2'b10), .BIT_WIDTH(8), .BLK_SEL(3'd0)) u_rbw (
        .clock(clock), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre),
        .blksel(blksel), .ad(ad), .di(di), .dout(dout_rbw));
    sp_bram16k #(.READ_MODE(1'b1), .WRITE_MODE(2'b00), .BIT_WIDTH(8), .BLK_SEL(3'd0)) u_pipe (
        .clock(clock), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre),
        .blksel(blksel), .ad(ad), .di(di), .dout(dout_pp));
    // blksel 5: W=8 with the first 256 bits set to one
    sp_bram16k #(.READ_MODE(1'b0), .WRITE_MODE(2'b00), .BIT_WIDTH(8), .BLK_SEL(3'd5),
                 .INIT_RAM_00({256{1'b1}})) u_init (
        .clock(clock), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre),
        .blksel(blksel), .ad(ad), .di(di), .dout(dout_in));
    // blksel 2: a W=32 instance and a W=1 instance
    sp_bram16k #(.READ_MODE(1'b0), .WRITE_MODE(2'b00), .BIT_WIDTH(32), .BLK_SEL(3'd2)) u_w32 (
        .clock(clock), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre),
        .blksel(blksel), .ad(ad), .di(di), .dout(dout_32));
    sp_bram16k #(.READ_MODE(1'b0), .WRITE_MODE(2'b00), .BIT_WIDTH(1), .BLK_SEL(3'd2)) u_w1 (
        .clock(clock), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre),
        .blksel(blksel), .ad(ad), .di(di), .dout(dout_1));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic w, input logic [2:0] bs, input logic [13:0] a, input logic [31:0] d);
        wre    = w;
        blksel = bs;
        ad     = a;
        di     = d;
        cyc();
    endtask

    function automatic logic [7:0] pat(input int a);
        logic [10:0] v;
        v = a[10:0];
        return v[7:0] ^ {v[9:8], v[10:8], v[10:8]};
    endfunction

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        oce     = 1'b1;
        wre     = 1'b1;
        blksel  = 3'd5;
        ad      = 14'd0;
        di      = 32'hEE;

        // Reset: a write is attempted at ad=0 of the init block and must be suppressed.
        cyc();
        cyc();
        check_eq("rst_dout_init", dout_in, 32'h0);
        check_eq("rst_dout_wt", dout_wt, 32'h0);
        check_eq("rst_dout_pipe", dout_pp, 32'h0);
        reset_n = 1'b1;
        op(1'b0, 3'd5, 14'd0, 32'h0);
        check_eq("rst_first_read", dout_in, 32'hFF);

        // INIT contents
        for (int k = 0; k < 32; k++) begin
            op(1'b0, 3'd5, 14'(k * 8), 32'h0);
            check_eq("init_ones", dout_in, 32'hFF);
        end
        op(1'b0, 3'd5, 14'd256, 32'h0);
        check_eq("init_zero_256", dout_in, 32'h0);

        // Sweep writes: normal holds 0, write-through follows di, read-before-write shows old 0
        for (int a = 0; a < 2048; a++) begin
            op(1'b1, 3'd0, 14'(a * 8), {24'h0, pat(a)});
            check_eq("sweep_wr_hold", dout_n, 32'h0);
            check_eq("sweep_wr_wt", dout_wt, {24'h0, pat(a)});
            check_eq("sweep_wr_rbw", dout_rbw, 32'h0);
        end
        // Sweep reads: the pipeline instance lags the bypass one by a cycle.
        for (int a = 0; a < 2048; a++) begin
            op(1'b0, 3'd0, 14'(a * 8), 32'h0);
            check_eq("sweep_rd", dout_n, {24'h0, pat(a)});
            if (a > 0) check_eq("sweep_rd_pipe", dout_pp, {24'h0, pat(a - 1)});
        end

        // Write modes at word 100 (ad=800)
        op(1'b1, 3'd0, 14'd800, 32'h3C);
        op(1'b0, 3'd0, 14'd808, 32'h0);
        check_eq("wm_prior_read", dout_n, 32'h65);
        op(1'b1, 3'd0, 14'd800, 32'h5A);
        check_eq("wm00_holds", dout_n, 32'h65);
        check_eq("wm01_through", dout_wt, 32'h5A);
        check_eq("wm10_old", dout_rbw, 32'h3C);
        op(1'b0, 3'd0, 14'd800, 32'h0);
        check_eq("wr_then_rd", dout_n, 32'h5A);
        check_eq("wr_then_rd_rbw", dout_rbw, 32'h5A);

        // Pipeline latency and oce hold
        op(1'b1, 3'd0, 14'd16, 32'hA5);
        op(1'b0, 3'd0, 14'd16, 32'h0);
        check_eq("pipe_edge1", dout_pp, 32'h5A);
        check_eq("bypass_edge1", dout_n, 32'hA5);
        op(1'b0, 3'd0, 14'd16, 32'h0);
        check_eq("pipe_edge2", dout_pp, 32'hA5);
        oce = 1'b0;
        op(1'b0, 3'd0, 14'd24, 32'h0);
        check_eq("pipe_oce0_a", dout_pp, 32'hA5);
        op(1'b0, 3'd0, 14'd24, 32'h0);
        check_eq("pipe_oce0_b", dout_pp, 32'hA5);
        oce = 1'b1;
        op(1'b0, 3'd0, 14'd24, 32'h0);
        check_eq("pipe_oce1", dout_pp, 32'h03);

        // Gating: ce low, then a foreign blksel, with a write of 0x77 pending
        ce = 1'b0;
        op(1'b1, 3'd0, 14'd24, 32'h77);
        check_eq("gate_ce_hold", dout_n, 32'h03);
        check_eq("gate_ce_wt_hold", dout_wt, 32'h03);
        ce = 1'b1;
        op(1'b1, 3'd3, 14'd24, 32'h77);
        check_eq("gate_bs_hold", dout_n, 32'h03);
        check_eq("gate_bs_wt_hold", dout_wt, 32'h03);
        op(1'b0, 3'd0, 14'd24, 32'h0);
        check_eq("gate_mem_kept", dout_n, 32'h03);

        // W=32 ignores ad[4:0]; W=1 addresses every bit
        op(1'b1, 3'd2, 14'd37, 32'hDEADBEEF);
        op(1'b1, 3'd2, 14'd70, 32'h00000001);
        op(1'b0, 3'd2, 14'd32, 32'h0);
        check_eq("w32_ad32", dout_32, 32'hDEADBEEF);
        check_eq("w1_bit32", dout_1, 32'h0);
        op(1'b0, 3'd2, 14'd63, 32'h0);
        check_eq("w32_ad63", dout_32, 32'hDEADBEEF);
        op(1'b0, 3'd2, 14'd0, 32'h0);
        check_eq("w32_ad0", dout_32, 32'h0);
        op(1'b0, 3'd2, 14'd37, 32'h0);
        check_eq("w1_bit37", dout_1, 32'h1);
        op(1'b0, 3'd2, 14'd38, 32'h0);
        check_eq("w1_bit38", dout_1, 32'h0);
        op(1'b0, 3'd2, 14'd70, 32'h0);
        check_eq("w1_bit70", dout_1, 32'h1);
        check_eq("w32_ad70", dout_32, 32'h1);
        op(1'b0, 3'd2, 14'd71, 32'h0);
        check_eq("w1_bit71", dout_1, 32'h0);

        // Asynchronous reset clears outputs at once, and the memory survives.
        op(1'b0, 3'd2, 14'd32, 32'h0);
        check_eq("pre_async", dout_32, 32'hDEADBEEF);
        reset_n = 1'b0;
        #1;
        check_eq("async_w32", dout_32, 32'h0);
        check_eq("async_pipe", dout_pp, 32'h0);
        check_eq("async_norm", dout_n, 32'h0);
        #1;
        reset_n = 1'b1;
        op(1'b0, 3'd2, 14'd32, 32'h0);
        check_eq("post_rst_mem", dout_32, 32'hDEADBEEF);
        op(1'b0, 3'd0, 14'd800, 32'h0);
        check_eq("post_rst_mem8", dout_n, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
